// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - round-robin IF/MEM arbiter sequencing one fixed-latency backing memory
module unified_mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 3
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   output logic              if_stall,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              mem_stall,
   output logic              bk_en,
   output logic              bk_we,
   output logic [ADDR_W-1:0] bk_addr,
   output logic [DATA_W-1:0] bk_wdata,
   input  logic [DATA_W-1:0] bk_rdata
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              grant_mem_q, grant_mem_d;
   logic              last_if_q, last_if_d;
   logic              bk_en_q, bk_en_d;
   logic              bk_we_q, bk_we_d;
   logic [ADDR_W-1:0] bk_addr_q, bk_addr_d;
   logic [DATA_W-1:0] bk_wdata_q, bk_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
   logic              if_ready_q, if_ready_d;
   logic              mem_ready_q, mem_ready_d;
   logic              pick_mem;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         grant_mem_q <= 1'b0;
         last_if_q   <= 1'b1;
         bk_en_q     <= 1'b0;
         bk_we_q     <= 1'b0;
         bk_addr_q   <= '0;
         bk_wdata_q  <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         if_ready_q  <= 1'b0;
         mem_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         grant_mem_q <= grant_mem_d;
         last_if_q   <= last_if_d;
         bk_en_q     <= bk_en_d;
         bk_we_q     <= bk_we_d;
         bk_addr_q   <= bk_addr_d;
         bk_wdata_q  <= bk_wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         if_ready_q  <= if_ready_d;
         mem_ready_q <= mem_ready_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_mem_d = grant_mem_q;
      last_if_d   = last_if_q;
      bk_en_d     = bk_en_q;
      bk_we_d     = bk_we_q;
      bk_addr_d   = bk_addr_q;
      bk_wdata_d  = bk_wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_ready_d  = 1'b0;
      mem_ready_d = 1'b0;
      // MEM wins a tie only when IF was the previous grantee
      pick_mem    = mem_req & (~if_req | last_if_q);

      case (state_q)
         IDLE: begin
            if (if_req | mem_req) begin
               grant_mem_d = pick_mem;
               last_if_d   = ~pick_mem;
               bk_en_d     = 1'b1;
               bk_we_d     = pick_mem & mem_we;
               bk_addr_d   = pick_mem ? mem_addr : if_addr;
               bk_wdata_d  = pick_mem ? mem_wdata : bk_wdata_q;
               cnt_d       = CNT_INIT;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) begin
               bk_en_d = 1'b0;
               state_d = RESP;
               if (grant_mem_q) begin
                  mem_ready_d = 1'b1;
                  if (!bk_we_q) mem_rdata_d = bk_rdata;
               end else begin
                  if_ready_d = 1'b1;
                  if_rdata_d = bk_rdata;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign if_rdata  = if_rdata_q;
   assign if_ready  = if_ready_q;
   assign if_stall  = if_req & ~if_ready_q;
   assign mem_rdata = mem_rdata_q;
   assign mem_ready = mem_ready_q;
   assign mem_stall = mem_req & ~mem_ready_q;
   assign bk_en     = bk_en_q;
   assign bk_we     = bk_we_q;
   assign bk_addr   = bk_addr_q;
   assign bk_wdata  = bk_wdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - testbench for unified_mem_arbiter (latency 3 and latency 1 instances)
module tb_unified_mem_arbiter;

   localparam int L = 3;

   logic        clk, rstb;
   logic        if_req, mem_req, mem_we;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic [31:0] if_rdata, mem_rdata, bk_addr, bk_wdata, bk_rdata;
   logic        if_ready, if_stall, mem_ready, mem_stall, bk_en, bk_we;

   logic        r1_if_req, r1_mem_req, r1_mem_we;
   logic [31:0] r1_if_addr, r1_mem_addr, r1_mem_wdata;
   logic [31:0] r1_if_rdata, r1_mem_rdata, r1_bk_addr, r1_bk_wdata, r1_bk_rdata;
   logic        r1_if_ready, r1_if_stall, r1_mem_ready, r1_mem_stall, r1_bk_en, r1_bk_we;

   logic        ovr_en;
   logic [31:0] ovr_data;
   bit   [31:0] mem3 [64];
   bit   [63:0] wr3;

   int passed = 0;
   int total  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input logic [5:0] i);
      return {16'hC0DE, 2'b00, i, 8'h5A};
   endfunction

   // backing memory for the latency-3 instance
   always @(posedge clk) begin
      if (bk_en && bk_we) begin
         mem3[bk_addr[7:2]] <= bk_wdata;
         wr3[bk_addr[7:2]]  <= 1'b1;
      end
   end
   assign bk_rdata    = ovr_en ? ovr_data :
                        (wr3[bk_addr[7:2]] ? mem3[bk_addr[7:2]] : pat(bk_addr[7:2]));
   assign r1_bk_rdata = r1_bk_addr ^ 32'h5A5A_0F0F;

   unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)) dut (
      .clk(clk), .rstb(rstb),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_stall(mem_stall),
      .bk_en(bk_en), .bk_we(bk_we), .bk_addr(bk_addr), .bk_wdata(bk_wdata), .bk_rdata(bk_rdata)
   );

   unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
      .clk(clk), .rstb(rstb),
      .if_req(r1_if_req), .if_addr(r1_if_addr), .if_rdata(r1_if_rdata), .if_ready(r1_if_ready),
      .if_stall(r1_if_stall),
      .mem_req(r1_mem_req), .mem_we(r1_mem_we), .mem_addr(r1_mem_addr), .mem_wdata(r1_mem_wdata),
      .mem_rdata(r1_mem_rdata), .mem_ready(r1_mem_ready), .mem_stall(r1_mem_stall),
      .bk_en(r1_bk_en), .bk_we(r1_bk_we), .bk_addr(r1_bk_addr), .bk_wdata(r1_bk_wdata),
      .bk_rdata(r1_bk_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstb = 1'b0;
      if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
      r1_if_req = 1'b0; r1_mem_req = 1'b0; r1_mem_we = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstb = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++; if (bk_en !== 1'b0) $display("FAIL rst_bk_en got %b exp 0", bk_en); else passed++;
      total++; if (bk_addr !== 32'h0) $display("FAIL rst_bk_addr got %h exp 0", bk_addr); else passed++;
      total++; if (bk_wdata !== 32'h0) $display("FAIL rst_bk_wdata got %h exp 0", bk_wdata); else passed++;
      total++; if (bk_we !== 1'b0) $display("FAIL rst_bk_we got %b exp 0", bk_we); else passed++;
      total++; if (if_rdata !== 32'h0) $display("FAIL rst_if_rdata got %h exp 0", if_rdata); else passed++;
      total++; if (mem_rdata !== 32'h0) $display("FAIL rst_mem_rdata got %h exp 0", mem_rdata); else passed++;
      total++; if ({if_ready, mem_ready} !== 2'b00) $display("FAIL rst_ready got %b exp 00", {if_ready, mem_ready}); else passed++;
      total++; if ({r1_bk_en, r1_bk_we, r1_bk_wdata} !== 34'h0) $display("FAIL rst_r1_bk got %h exp 0", {r1_bk_en, r1_bk_we, r1_bk_wdata}); else passed++;
      tick(); rstb = 1'b1;
      @(negedge clk);
      total++; if ({if_stall, mem_stall, bk_en} !== 3'b000) $display("FAIL rst_idle got %b exp 000", {if_stall, mem_stall, bk_en}); else passed++;
   endtask

   task automatic test_if_read();
      do_reset();
      ovr_en = 1'b1; ovr_data = 32'h8C22_0004;
      tick(); if_req = 1'b1; if_addr = 32'h0040_0000;
      @(negedge clk);
      total++; if ({if_stall, bk_en} !== 2'b10) $display("FAIL ifrd_c0 got %b exp 10", {if_stall, bk_en}); else passed++;
      for (int i = 1; i <= 5; i++) begin
         tick(); if (i == 5) if_req = 1'b0;
         @(negedge clk);
         total++; if (bk_en !== (i <= 3)) $display("FAIL ifrd_bk_en cyc%0d got %b exp %b", i, bk_en, i <= 3); else passed++;
         total++; if (if_ready !== (i == 4)) $display("FAIL ifrd_ready cyc%0d got %b exp %b", i, if_ready, i == 4); else passed++;
         total++; if (if_stall !== (i < 4)) $display("FAIL ifrd_stall cyc%0d got %b exp %b", i, if_stall, i < 4); else passed++;
         if (i <= 3) begin
            total++; if ({bk_we, bk_addr} !== {1'b0, 32'h0040_0000}) $display("FAIL ifrd_cmd cyc%0d got %b/%h exp 0/00400000", i, bk_we, bk_addr); else passed++;
         end
      end
      total++; if (if_rdata !== 32'h8C22_0004) $display("FAIL ifrd_rdata got %h exp 8c220004", if_rdata); else passed++;
      ovr_en = 1'b0;
   endtask

   task automatic test_both_rise();
      int mem_at = -1;
      int if_at  = -1;
      do_reset();
      tick(); if_req = 1'b1; if_addr = 32'h104; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h20;
      @(negedge clk);
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (mem_at == i - 1) mem_req = 1'b0;
         if (if_at == i - 1) if_req = 1'b0;
         @(negedge clk);
         if (i == 1) begin
            total++; if (bk_addr !== 32'h20) $display("FAIL both_first_grant got %h exp 00000020", bk_addr); else passed++;
         end
         if (mem_ready) mem_at = i;
         if (if_ready) if_at = i;
      end
      total++; if (mem_at !== 4) $display("FAIL both_mem_ready_cyc got %0d exp 4", mem_at); else passed++;
      total++; if (if_at !== 9) $display("FAIL both_if_ready_cyc got %0d exp 9", if_at); else passed++;
      total++; if (if_rdata !== pat(6'd1)) $display("FAIL both_if_rdata got %h exp %h", if_rdata, pat(6'd1)); else passed++;
      total++; if (mem_rdata !== pat(6'd8)) $display("FAIL both_mem_rdata got %h exp %h", mem_rdata, pat(6'd8)); else passed++;
   endtask

   task automatic test_alternate();
      int n    = 0;
      int last = 0;
      do_reset();
      tick(); if_req = 1'b1; if_addr = 32'h104; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h20;
      for (int i = 1; i <= 40 && n < 6; i++) begin
         tick();
         @(negedge clk);
         if (mem_ready || if_ready) begin
            n++;
            total++; if ({mem_ready, if_ready} !== ((n % 2 == 1) ? 2'b10 : 2'b01)) $display("FAIL alt_order n%0d got %b", n, {mem_ready, if_ready}); else passed++;
            total++; if (i - last !== ((n == 1) ? 4 : 5)) $display("FAIL alt_spacing n%0d got %0d exp %0d", n, i - last, (n == 1) ? 4 : 5); else passed++;
            last = i;
         end
      end
      total++; if (n !== 6) $display("FAIL alt_count got %0d exp 6", n); else passed++;
      tick(); if_req = 1'b0; mem_req = 1'b0;
   endtask

   task automatic test_store_load();
      tick(); mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h1000_0000; mem_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      for (int i = 1; i <= 4; i++) begin
         tick(); @(negedge clk);
         if (i <= 3) begin
            total++; if ({bk_en, bk_we, bk_wdata} !== {2'b11, 32'hDEAD_BEEF}) $display("FAIL st_cmd cyc%0d got %b%b/%h exp 11/deadbeef", i, bk_en, bk_we, bk_wdata); else passed++;
         end
         total++; if (mem_ready !== (i == 4)) $display("FAIL st_ready cyc%0d got %b exp %b", i, mem_ready, i == 4); else passed++;
      end
      total++; if (mem_rdata !== pat(6'd8)) $display("FAIL st_rdata_held got %h exp %h", mem_rdata, pat(6'd8)); else passed++;
      tick(); mem_we = 1'b0;
      @(negedge clk);
      for (int i = 1; i <= 4; i++) begin
         tick(); @(negedge clk);
         if (i <= 3) begin
            total++; if ({bk_en, bk_we} !== 2'b10) $display("FAIL ld_cmd cyc%0d got %b exp 10", i, {bk_en, bk_we}); else passed++;
         end
         total++; if (mem_ready !== (i == 4)) $display("FAIL ld_ready cyc%0d got %b exp %b", i, mem_ready, i == 4); else passed++;
      end
      total++; if (mem_rdata !== 32'hDEAD_BEEF) $display("FAIL ld_rdata got %h exp deadbeef", mem_rdata); else passed++;
      tick(); mem_req = 1'b0;
   endtask

   task automatic test_reset_midbusy();
      tick(); if_req = 1'b1; if_addr = 32'h0040_0000;
      tick();
      @(negedge clk);
      total++; if (bk_en !== 1'b1) $display("FAIL rmb_busy1 got %b exp 1", bk_en); else passed++;
      tick(); rstb = 1'b0; #1;
      total++; if ({bk_en, bk_we, if_ready} !== 3'b000) $display("FAIL rmb_ctrl got %b exp 000", {bk_en, bk_we, if_ready}); else passed++;
      total++; if (if_rdata !== 32'h0) $display("FAIL rmb_if_rdata got %h exp 0", if_rdata); else passed++;
      total++; if (bk_addr !== 32'h0) $display("FAIL rmb_bk_addr got %h exp 0", bk_addr); else passed++;
      @(negedge clk);
      total++; if (if_ready !== 1'b0) $display("FAIL rmb_no_ready got %b exp 0", if_ready); else passed++;
      tick(); rstb = 1'b1;
      @(negedge clk);
      total++; if ({bk_en, if_stall} !== 2'b01) $display("FAIL rmb_idle got %b exp 01", {bk_en, if_stall}); else passed++;
      for (int i = 1; i <= 5; i++) begin
         tick(); if (i == 5) if_req = 1'b0;
         @(negedge clk);
         total++; if (bk_en !== (i <= 3)) $display("FAIL rmb_bk_en cyc%0d got %b exp %b", i, bk_en, i <= 3); else passed++;
         total++; if (if_ready !== (i == 4)) $display("FAIL rmb_ready cyc%0d got %b exp %b", i, if_ready, i == 4); else passed++;
      end
      total++; if (if_rdata !== 32'hDEAD_BEEF) $display("FAIL rmb_rdata got %h exp deadbeef", if_rdata); else passed++;
   endtask

   task automatic test_lat1();
      int n    = 0;
      int last = 0;
      tick(); r1_if_req = 1'b1; r1_if_addr = 32'h40;
      @(negedge clk);
      for (int i = 1; i <= 3; i++) begin
         tick(); if (i == 3) r1_if_req = 1'b0;
         @(negedge clk);
         total++; if ({r1_bk_en, r1_bk_we} !== {(i == 1), 1'b0}) $display("FAIL l1_bk_en cyc%0d got %b exp %b", i, r1_bk_en, i == 1); else passed++;
         total++; if (r1_if_ready !== (i == 2)) $display("FAIL l1_ready cyc%0d got %b exp %b", i, r1_if_ready, i == 2); else passed++;
         total++; if (r1_if_stall !== (i == 1)) $display("FAIL l1_stall cyc%0d got %b exp %b", i, r1_if_stall, i == 1); else passed++;
      end
      total++; if (r1_if_rdata !== (32'h40 ^ 32'h5A5A_0F0F)) $display("FAIL l1_rdata got %h exp %h", r1_if_rdata, 32'h40 ^ 32'h5A5A_0F0F); else passed++;
      tick(); r1_if_req = 1'b1; r1_mem_req = 1'b1; r1_mem_we = 1'b0; r1_mem_addr = 32'h80;
      for (int i = 1; i <= 30 && n < 4; i++) begin
         tick(); @(negedge clk);
         if (r1_mem_ready || r1_if_ready) begin
            n++;
            total++; if ({r1_mem_ready, r1_if_ready} !== ((n % 2 == 1) ? 2'b10 : 2'b01)) $display("FAIL l1_order n%0d got %b", n, {r1_mem_ready, r1_if_ready}); else passed++;
            total++; if (i - last !== ((n == 1) ? 2 : 3)) $display("FAIL l1_spacing n%0d got %0d exp %0d", n, i - last, (n == 1) ? 2 : 3); else passed++;
            total++; if (r1_mem_stall !== 1'b0 && r1_mem_ready) $display("FAIL l1_mem_stall n%0d got %b exp 0", n, r1_mem_stall); else passed++;
            last = i;
         end
      end
      total++; if (n !== 4) $display("FAIL l1_count got %0d exp 4", n); else passed++;
      total++; if (r1_mem_rdata !== (32'h80 ^ 32'h5A5A_0F0F)) $display("FAIL l1_mem_rdata got %h exp %h", r1_mem_rdata, 32'h80 ^ 32'h5A5A_0F0F); else passed++;
      tick(); r1_if_req = 1'b0; r1_mem_req = 1'b0;
   endtask

   // Transaction-level model: an access sampled at cycle t owns the memory until t+L+1,
   // with bk_en over t+1..t+L and the ready pulse at t+L+1.
   task automatic test_random(input int ncyc);
      logic [31:0] m_mem [64];
      logic [31:0] exp_if_rd, exp_mem_rd, rd_val, c_addr, c_wdata;
      logic        exp_en, exp_ifr, exp_memr;
      bit          act, g_mem, last_if, c_we, drop_if, drop_mem;
      int          t_start, free_at;
      for (int i = 0; i < 64; i++) m_mem[i] = wr3[i] ? mem3[i] : pat(6'(i));
      do_reset();
      exp_if_rd = 32'h0; exp_mem_rd = 32'h0; rd_val = 32'h0; c_addr = 32'h0; c_wdata = 32'h0;
      act = 1'b0; g_mem = 1'b0; last_if = 1'b1; c_we = 1'b0; drop_if = 1'b0; drop_mem = 1'b0;
      t_start = -100; free_at = 0;
      for (int k = 0; k < ncyc; k++) begin
         tick();
         if (drop_if) begin if_req = 1'b0; drop_if = 1'b0; end
         if (drop_mem) begin mem_req = 1'b0; drop_mem = 1'b0; end
         if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1'b1; if_addr = $urandom() & 32'hFFFF_FFFC;
         end
         if (!mem_req && $urandom_range(0, 2) == 0) begin
            mem_req = 1'b1; mem_we = 1'($urandom_range(0, 1));
            mem_addr = $urandom() & 32'hFFFF_FFFC; mem_wdata = $urandom();
         end
         @(negedge clk);
         exp_en   = act && (k >= t_start + 1) && (k <= t_start + L);
         exp_ifr  = act && !g_mem && (k == t_start + L + 1);
         exp_memr = act && g_mem && (k == t_start + L + 1);
         if (exp_ifr) exp_if_rd = rd_val;
         if (exp_memr && !c_we) exp_mem_rd = rd_val;
         total++; if (bk_en !== exp_en) $display("FAIL rnd_bk_en cyc%0d got %b exp %b", k, bk_en, exp_en); else passed++;
         total++; if ({if_ready, mem_ready} !== {exp_ifr, exp_memr}) $display("FAIL rnd_ready cyc%0d got %b exp %b", k, {if_ready, mem_ready}, {exp_ifr, exp_memr}); else passed++;
         total++; if ({if_stall, mem_stall} !== {if_req & ~exp_ifr, mem_req & ~exp_memr}) $display("FAIL rnd_stall cyc%0d got %b", k, {if_stall, mem_stall}); else passed++;
         total++; if (if_rdata !== exp_if_rd) $display("FAIL rnd_if_rdata cyc%0d got %h exp %h", k, if_rdata, exp_if_rd); else passed++;
         total++; if (mem_rdata !== exp_mem_rd) $display("FAIL rnd_mem_rdata cyc%0d got %h exp %h", k, mem_rdata, exp_mem_rd); else passed++;
         if (exp_en) begin
            total++; if ({bk_we, bk_addr} !== {c_we, c_addr}) $display("FAIL rnd_cmd cyc%0d got %b/%h exp %b/%h", k, bk_we, bk_addr, c_we, c_addr); else passed++;
            if (c_we) begin
               total++; if (bk_wdata !== c_wdata) $display("FAIL rnd_wdata cyc%0d got %h exp %h", k, bk_wdata, c_wdata); else passed++;
            end
         end
         if (exp_ifr) drop_if = 1'b1;
         if (exp_memr) drop_mem = 1'b1;
         if (k >= free_at && (if_req || mem_req)) begin
            g_mem   = mem_req && (!if_req || last_if);
            last_if = !g_mem;
            act     = 1'b1;
            t_start = k;
            free_at = k + L + 2;
            c_addr  = g_mem ? mem_addr : if_addr;
            c_we    = g_mem && mem_we;
            c_wdata = mem_wdata;
            rd_val  = m_mem[c_addr[7:2]];
            if (c_we) m_mem[c_addr[7:2]] = c_wdata;
         end
      end
      tick(); if_req = 1'b0; mem_req = 1'b0;
   endtask

   initial begin
      rstb = 1'b0; ovr_en = 1'b0; ovr_data = 32'h0;
      if_req = 1'b0; if_addr = 32'h0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
      r1_if_req = 1'b0; r1_if_addr = 32'h0; r1_mem_req = 1'b0; r1_mem_we = 1'b0;
      r1_mem_addr = 32'h0; r1_mem_wdata = 32'h0;
      test_reset();
      test_if_read();
      test_both_rise();
      test_alternate();
      test_store_load();
      test_reset_midbusy();
      test_lat1();
      test_random(400);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
